// File: rtl/riscv_pkg.sv
// riscv_pkg: shared funct3 access codes, LSU state encoding and byte-lane masks.
package riscv_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [3:0] LANE_B = 4'b0001;
   localparam logic [3:0] LANE_H = 4'b0011;
   localparam logic [3:0] LANE_W = 4'b1111;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} lsu_state_e;
   // Unsupported size codes fall through to word, so anything not b/h is checked as a word.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      return (f3[1:0] == F3_H[1:0] && off[0]) ||
             (f3[1:0] != F3_B[1:0] && f3[1:0] != F3_H[1:0] && off != 2'b00);
   endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: lane selection with sign/zero extension for loads, plus store lane strobes/replication.
module load_extend
   import riscv_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_sdata,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_f3,
   output logic [31:0] o_load,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata
);
   logic       w_is_b, w_is_h, w_uns;
   logic [7:0]  w_b;
   logic [15:0] w_h;
   always_comb begin
      w_is_b  = i_f3[1:0] == F3_B[1:0];
      w_is_h  = i_f3[1:0] == F3_H[1:0];
      w_uns   = i_f3 == F3_BU || i_f3 == F3_HU;
      w_b     = 8'(i_rdata >> {i_off, 3'b000});
      w_h     = 16'(i_rdata >> {i_off[1], 4'b0000});
      o_load  = w_is_b ? {{24{~w_uns & w_b[7]}}, w_b} :
                w_is_h ? {{16{~w_uns & w_h[15]}}, w_h} : i_rdata;
      o_wstrb = w_is_b ? LANE_B << i_off :
                w_is_h ? LANE_H << {i_off[1], 1'b0} : LANE_W;
      o_wdata = w_is_b ? {4{i_sdata[7:0]}} :
                w_is_h ? {2{i_sdata[15:0]}} : i_sdata;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single outstanding load/store over a req/ready memory port with timeout abort.
// Optional MISALIGN_TRAP_EN: misaligned h/w accesses complete immediately with bus_err.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] ReadData2,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic        bus_err
);
   lsu_state_e  r_state, w_next;
   logic [31:0] r_addr, r_sdata, r_load;
   logic [2:0]  r_f3;
   logic        r_we, r_err;
   logic [15:0] r_cnt;
   logic        w_start, w_mis, w_tmo;
   logic [31:0] w_ext, w_wdata;
   logic [3:0]  w_wstrb;

`ifdef MISALIGN_TRAP_EN
   assign w_mis = misaligned(funct3, ALUResult[1:0]);
`else
   assign w_mis = 1'b0;
`endif

   load_extend u_ext (
      .i_rdata(mem_rdata), .i_sdata(r_sdata), .i_off(r_addr[1:0]), .i_f3(r_f3),
      .o_load(w_ext), .o_wstrb(w_wstrb), .o_wdata(w_wdata)
   );

   always_comb begin
      w_start = MemRead | MemWrite;
      w_tmo   = r_cnt == 16'(TIMEOUT_CYCLES - 1);
      w_next  = r_state;
      case (r_state)
         S_IDLE:  w_next = w_start ? (w_mis ? S_DONE : S_REQ) : S_IDLE;
         S_REQ:   w_next = (mem_ready || w_tmo) ? S_DONE : S_REQ;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_sdata <= '0;
         r_f3    <= '0;
         r_we    <= 1'b0;
         r_cnt   <= '0;
         r_load  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_start) begin
            r_addr  <= ALUResult;
            r_sdata <= ReadData2;
            r_f3    <= funct3;
            r_we    <= MemWrite;
            r_cnt   <= '0;
            r_load  <= '0;
            r_err   <= w_mis;
         end else if (r_state == S_REQ) begin
            // Ready is checked before the limit so a last-cycle ready still succeeds.
            if (mem_ready) begin
               r_load <= r_we ? 32'h0 : w_ext;
               r_err  <= 1'b0;
            end else if (w_tmo) begin
               r_load <= '0;
               r_err  <= 1'b1;
            end else
               r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign mem_req   = r_state == S_REQ;
   assign mem_we    = r_we;
   assign mem_addr  = {r_addr[31:2], 2'b00};
   assign mem_wstrb = r_we ? w_wstrb : 4'b0000;
   assign mem_wdata = w_wdata;
   assign load_data = r_load;
   assign lsu_done  = r_state == S_DONE;
   assign bus_err   = lsu_done & r_err;
   assign lsu_busy  = (r_state == S_IDLE && w_start) || r_state == S_REQ;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed vectors plus reset-mid-request sequence.
module tb_load_store_unit;
   logic        clk = 0, rst = 1;
   logic        MemRead = 0, MemWrite = 0, mem_ready = 0;
   logic [2:0]  funct3 = 0;
   logic [31:0] ALUResult = 0, ReadData2 = 0, mem_rdata = 0;
   logic        mem_req, mem_we, lsu_busy, lsu_done, bus_err;
   logic [31:0] mem_addr, mem_wdata, load_data;
   logic [3:0]  mem_wstrb;
   int n_pass = 0, n_tot = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
      .ALUResult(ALUResult), .ReadData2(ReadData2), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .load_data(load_data), .lsu_busy(lsu_busy), .lsu_done(lsu_done),
      .bus_err(bus_err)
   );

   typedef struct {
      string       name;
      logic        mr, mw;
      logic [2:0]  f3;
      logic [31:0] addr, sd, rdata;
      int          delay;
      logic        req;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata, maddr, load;
      logic        err;
      int          busy;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic txn(input vec_t v);
      int  busy;
      bit  seen, saw_req;
      busy = 0; seen = 0; saw_req = 0;
      @(negedge clk);
      MemRead = v.mr; MemWrite = v.mw; funct3 = v.f3; ALUResult = v.addr; ReadData2 = v.sd;
      mem_rdata = v.rdata;
      #1 chk({v.name, ".busy_start"}, 32'(lsu_busy), 1);
      if (lsu_busy) busy++;
      @(posedge clk); #1;
      MemRead = 0; MemWrite = 0;
      for (int c = 0; c < 20; c++) begin
         if (lsu_done) begin seen = 1; break; end
         if (c == 0 && mem_req) begin
            saw_req = 1;
            chk({v.name, ".we"}, 32'(mem_we), 32'(v.we));
            chk({v.name, ".addr"}, mem_addr, v.maddr);
            chk({v.name, ".wstrb"}, 32'(mem_wstrb), 32'(v.wstrb));
            if (v.we) chk({v.name, ".wdata"}, mem_wdata, v.wdata);
         end
         if (lsu_busy) busy++;
         mem_ready = (c == v.delay);
         @(posedge clk); #1;
         mem_ready = 0;
      end
      chk({v.name, ".done_seen"}, 32'(seen), 1);
      chk({v.name, ".saw_req"}, 32'(saw_req), 32'(v.req));
      chk({v.name, ".load"}, load_data, v.load);
      chk({v.name, ".err"}, 32'(bus_err), 32'(v.err));
      chk({v.name, ".busy_cycles"}, busy, v.busy);
      chk({v.name, ".done_busy"}, 32'({mem_req, lsu_busy}), 0);
      @(posedge clk); #1;
      chk({v.name, ".done_pulse"}, 32'(lsu_done), 0);
   endtask

   vec_t vt[$];

   initial begin
      vt.push_back('{"sw",     0,1,3'b010,32'h100,32'hDEADBEEF,0,           1,1,1,4'hF,32'hDEADBEEF,32'h100,0,0,3});
      vt.push_back('{"lb",     1,0,3'b000,32'h103,0,32'h80FF0000,           0,1,0,4'h0,0,32'h100,32'hFFFFFF80,0,2});
      vt.push_back('{"lbu",    1,0,3'b100,32'h103,0,32'h80FF0000,           0,1,0,4'h0,0,32'h100,32'h00000080,0,2});
      vt.push_back('{"lhu",    1,0,3'b101,32'h102,0,32'h80FF0000,           0,1,0,4'h0,0,32'h100,32'h000080FF,0,2});
      vt.push_back('{"lh",     1,0,3'b001,32'h102,0,32'h80FF0000,           0,1,0,4'h0,0,32'h100,32'hFFFF80FF,0,2});
      vt.push_back('{"lb_pos", 1,0,3'b000,32'h100,0,32'h0000007F,           0,1,0,4'h0,0,32'h100,32'h0000007F,0,2});
      vt.push_back('{"sb",     0,1,3'b000,32'h201,32'h00000012,0,           0,1,1,4'b0010,32'h12121212,32'h200,0,0,2});
      vt.push_back('{"sh",     0,1,3'b001,32'h202,32'h0000ABCD,0,           0,1,1,4'b1100,32'hABCDABCD,32'h200,0,0,2});
      vt.push_back('{"both_sb",1,1,3'b000,32'h203,32'h000000A5,0,           0,1,1,4'b1000,32'hA5A5A5A5,32'h200,0,0,2});
      vt.push_back('{"f3_011", 0,1,3'b011,32'h10C,32'h55AA55AA,0,           0,1,1,4'hF,32'h55AA55AA,32'h10C,0,0,2});
      vt.push_back('{"lw_lim", 1,0,3'b010,32'h104,0,32'h12345678,           3,1,0,4'h0,0,32'h104,32'h12345678,0,5});
      vt.push_back('{"tmo",    1,0,3'b010,32'h108,0,32'hFFFFFFFF,         255,1,0,4'h0,0,32'h108,0,1,5});
`ifdef MISALIGN_TRAP_EN
      vt.push_back('{"lw_mis", 1,0,3'b010,32'h102,0,32'hCAFEF00D,           0,0,0,4'h0,0,32'h100,0,1,1});
`else
      vt.push_back('{"lw_mis", 1,0,3'b010,32'h102,0,32'hCAFEF00D,           0,1,0,4'h0,0,32'h100,32'hCAFEF00D,0,2});
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.outs", {mem_req, mem_we, mem_wstrb, lsu_done, bus_err, lsu_busy}, 0);
      chk("rst.load", load_data, 0);
      chk("rst.addr", mem_addr, 0);
      chk("rst.wdata", mem_wdata, 0);
      rst = 0;
      foreach (vt[i]) txn(vt[i]);
      @(negedge clk);
      MemRead = 1; funct3 = 3'b010; ALUResult = 32'h300;
      @(posedge clk); #1;
      MemRead = 0;
      chk("rstmid.req_before", 32'(mem_req), 1);
      rst = 1;
      @(posedge clk); #1;
      chk("rstmid.after", {mem_req, lsu_busy, lsu_done}, 0);
      rst = 0;
      txn('{"lw_after_rst",1,0,3'b010,32'h300,0,32'h0BADF00D,1,1,0,4'h0,0,32'h300,32'h0BADF00D,0,3});
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
